// File: rtl/uart_result_tx_pkg.sv
// uart_result_tx_pkg
//   Shared types and constants for the result-byte UART transmitter.
//   tx_state_t : frame sequencer states (IDLE, START, DATA, STOP)
//   DATA_BITS  : payload bits per frame (byte channel, fixed at 8)
//   FRAME_BITS : start + data + stop bit periods per frame
package uart_result_tx_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = DATA_BITS + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/baud_tick_counter.sv
// baud_tick_counter
//   Divides the system clock down to one bit period.
//   clk     in  : system clock, rising edge
//   rst     in  : synchronous active-high reset
//   clear   in  : holds the count at 0 (used while the line is idle)
//   bit_end out : one-cycle pulse on the last clock of each bit period
module baud_tick_counter #(
    parameter int unsigned CLOCKS_PER_BAUD = 1250
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned CW = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BAUD - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bit_end = (r_count == LAST);

endmodule

// File: rtl/uart_result_tx.sv
// uart_result_tx
//   Serialises one result byte per valid/ready handshake as 8N1 UART,
//   LSB first, on a single registered output pin.
//   clk           in  : system clock, rising edge
//   rst           in  : synchronous active-high reset (aborts any frame)
//   tx_byte       in  : byte to send, sampled only on handshake
//   tx_byte_valid in  : producer has a byte
//   tx_byte_ready out : high only while idle
//   tx            out : serial line, idle high
//   tx_busy       out : high from start bit through stop bit
module uart_result_tx
    import uart_result_tx_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BAUD = 1250
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_byte,
    input  logic                 tx_byte_valid,
    output logic                 tx_byte_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    if (CLOCKS_PER_BAUD < 2) begin : g_bad_clocks_per_baud
        $error("uart_result_tx: CLOCKS_PER_BAUD must be >= 2");
    end

    localparam int unsigned IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    tx_state_t            r_state;
    tx_state_t            w_next_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_next_shift;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_next_idx;
    logic                 r_tx;
    logic                 w_next_tx;
    logic                 w_bit_end;
    logic                 w_clear;

    assign w_clear = (r_state == IDLE);

    baud_tick_counter #(
        .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .bit_end(w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_shift <= w_next_shift;
            r_idx   <= w_next_idx;
            r_tx    <= w_next_tx;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_shift = r_shift;
        w_next_idx   = r_idx;
        unique case (r_state)
            IDLE: begin
                if (tx_byte_valid) begin
                    w_next_state = START;
                    w_next_shift = tx_byte;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_next_state = DATA;
                    w_next_idx   = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_next_shift = r_shift >> 1;
                    w_next_idx   = r_idx + 1'b1;
                    if (r_idx == LAST_BIT) begin
                        w_next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The line level is decoded from the next state and registered, so tx
    // changes on the same edge as the state and never glitches.
    always_comb begin
        w_next_tx = 1'b1;
        case (w_next_state)
            START:   w_next_tx = 1'b0;
            DATA:    w_next_tx = w_next_shift[0];
            default: w_next_tx = 1'b1;
        endcase
    end

    assign tx            = r_tx;
    assign tx_byte_ready = (r_state == IDLE);
    assign tx_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_result_tx.sv
module tb_uart_result_tx;

    localparam int unsigned CPB = 4;

    logic       clk           = 1'b0;
    logic       rst           = 1'b1;
    logic [7:0] tx_byte       = 8'h00;
    logic       tx_byte_valid = 1'b0;
    logic       tx_byte_ready;
    logic       tx;
    logic       tx_busy;

    uart_result_tx #(
        .CLOCKS_PER_BAUD(CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_byte      (tx_byte),
        .tx_byte_valid(tx_byte_valid),
        .tx_byte_ready(tx_byte_ready),
        .tx           (tx),
        .tx_busy      (tx_busy)
    );

    always #5 clk = ~clk;

    int n_vectors     = 0;
    int n_miscompares = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } sb_t;

    sb_t        sb_q[$];
    int         cyc      = 0;
    int         hs_prev  = -1;
    int         hs_last  = -1;
    int         rx_count = 0;
    bit         rx_active = 1'b0;
    int         rx_cnt   = 0;
    logic [7:0] rx_sh    = 8'h00;
    sb_t        rx_exp;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard push on predicted handshakes plus a mid-bit reference
    // sampler. Inputs only change just after posedge, so the negedge view
    // predicts exactly what the next rising edge will do.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb_q.delete();
            rx_active = 1'b0;
        end else begin
            if (tx_byte_valid && tx_byte_ready) begin
                sb_q.push_back('{tx_byte, cyc});
                hs_prev = hs_last;
                hs_last = cyc;
            end
            if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                    if (sb_q.size() == 0) begin
                        check_eq("sb_underflow", 32'd1, 32'd0);
                        rx_exp.data = 8'h00;
                        rx_exp.cyc  = cyc - 1;
                    end else begin
                        rx_exp = sb_q.pop_front();
                        check_eq("start_latency", cyc - rx_exp.cyc, 32'd1);
                    end
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == 2) begin
                    check_eq("start_bit", tx, 1'b0);
                end else if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) begin
                    rx_sh = {tx, rx_sh[7:1]};
                end else if (rx_cnt == 38) begin
                    check_eq("stop_bit", tx, 1'b1);
                    check_eq("rx_byte", rx_sh, rx_exp.data);
                    rx_count++;
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise valid and wait until the edge that accepts the byte.
    task automatic send(input logic [7:0] b, input bit keep);
        bit hs;
        hs            = 1'b0;
        tx_byte       = b;
        tx_byte_valid = 1'b1;
        for (int i = 0; i < 200 && !hs; i++) begin
            hs = tx_byte_ready;
            tick();
        end
        if (!keep) tx_byte_valid = 1'b0;
        check_eq("send_accept", hs, 1'b1);
    endtask

    // Called just after the handshake edge; checks every cycle of the frame.
    // mode 1: pulse valid mid-frame; mode 2: raise and hold valid mid-frame.
    task automatic frame_check(input logic [7:0] b, input int mode);
        for (int k = 0; k < 40; k++) begin
            int   p;
            logic e;
            p = k / 4;
            if (p == 0)      e = 1'b0;
            else if (p == 9) e = 1'b1;
            else             e = b[p-1];
            check_eq("frame_tx", tx, e);
            check_eq("frame_ready", tx_byte_ready, 1'b0);
            check_eq("frame_busy", tx_busy, 1'b1);
            if (mode != 0 && k == 20) begin
                tx_byte       = 8'h3C;
                tx_byte_valid = 1'b1;
            end
            if (mode == 1 && k == 21) tx_byte_valid = 1'b0;
            tick();
        end
        check_eq("post_tx", tx, 1'b1);
        check_eq("post_ready", tx_byte_ready, 1'b1);
        check_eq("post_busy", tx_busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with valid high: nothing may start.
        rst           = 1'b1;
        tx_byte       = 8'h11;
        tx_byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_tx", tx, 1'b1);
            check_eq("rst_ready", tx_byte_ready, 1'b1);
            check_eq("rst_busy", tx_busy, 1'b0);
        end
        // First edge with rst low accepts the held byte.
        rst = 1'b0;
        tick();
        tx_byte_valid = 1'b0;
        frame_check(8'h11, 0);
        repeat (3) tick();

        // 0xA5 with a one-cycle valid pulse mid-frame that must be ignored.
        send(8'hA5, 1'b0);
        frame_check(8'hA5, 1);
        repeat (2) tick();

        // 0xA5 with valid raised mid-frame and held: 0x3C follows at once.
        send(8'hA5, 1'b0);
        frame_check(8'hA5, 2);
        tick();
        tx_byte_valid = 1'b0;
        check_eq("hold_pitch", hs_last - hs_prev, 32'd41);
        frame_check(8'h3C, 0);
        repeat (2) tick();

        // Back-to-back 0x00 then 0xFF, valid never dropped.
        send(8'h00, 1'b1);
        tx_byte = 8'hFF;
        frame_check(8'h00, 0);
        tick();
        tx_byte_valid = 1'b0;
        check_eq("b2b_pitch", hs_last - hs_prev, 32'd41);
        frame_check(8'hFF, 0);
        repeat (2) tick();

        // Reset during data bit 3 of 0x5A.
        send(8'h5A, 1'b0);
        repeat (17) tick();
        check_eq("pre_abort_tx", tx, 1'b1);
        rst = 1'b1;
        tick();
        check_eq("abort_tx", tx, 1'b1);
        check_eq("abort_busy", tx_busy, 1'b0);
        rst = 1'b0;
        tick();
        check_eq("abort_ready", tx_byte_ready, 1'b1);
        check_eq("abort_idle_tx", tx, 1'b1);
        send(8'h81, 1'b0);
        frame_check(8'h81, 0);

        // Random bytes with random idle gaps, checked by the sampler.
        for (int n = 0; n < 200; n++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            send(b, 1'b0);
            repeat ($urandom_range(0, 5)) tick();
        end
        for (int i = 0; i < 100 && (sb_q.size() != 0 || rx_active); i++) tick();
        check_eq("drain", sb_q.size(), 32'd0);
        check_eq("rx_count", rx_count, 32'd207);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/uart_result_tx.md
Name: uart_result_tx

Overview:
- Transmit side of the ice40 uncore byte channel; the UART receiver delivers x into the computation block, and this block returns the block's 8-bit result to the host.
- Accepts one result byte per valid/ready handshake and serializes it as 8N1 UART, LSB first, on a single pin.
- Sits between the computation-block output register and the board TX pin.

Parameters:
- CLOCKS_PER_BAUD, 1250, clock cycles per bit period (12 MHz / 9600 baud); legal range >= 2; elaboration error otherwise.
- DATA_BITS, 8, payload bits per frame; fixed at 8 for the byte channel, exposed only for the package constant.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_byte  in  8  result byte to send; sampled only on handshake.
- tx_byte_valid  in  1  producer has a byte.
- tx_byte_ready  out  1  block can accept a byte (high only in IDLE).
- tx  out  1  serial line; idle high.
- tx_busy  out  1  high while a frame is in progress (START..STOP).

Behaviour:
- Reset (rst high at an edge): state=IDLE, tx=1, tx_byte_ready=1, tx_busy=0, baud counter=0, bit index=0, shift register=0. Reset mid-frame aborts at once; tx returns high the next cycle and any partial byte is dropped.
- Handshake: transfer occurs on an edge where tx_byte_valid && tx_byte_ready. tx_byte is latched into the shift register. tx_byte_valid with ready low is ignored, and the producer must hold it. tx_byte may change freely when no transfer occurs.
- States:
  - IDLE: tx=1, ready=1. On handshake go to START, counter=0.
  - START: tx=0 for CLOCKS_PER_BAUD cycles, then go to DATA with bit index=0.
  - DATA: tx=shift[0] for CLOCKS_PER_BAUD cycles per bit. At each bit end, shift right and increment the index. After bit DATA_BITS-1 completes, go to STOP.
  - STOP: tx=1 for CLOCKS_PER_BAUD cycles, then go to IDLE.
- Timing:
  - tx falls on the cycle after the handshake edge; tx is driven from a register, so it is glitch-free.
  - A frame occupies exactly 10*CLOCKS_PER_BAUD cycles.
  - ready re-asserts the cycle after STOP ends, so the minimum handshake-to-handshake pitch is 10*CLOCKS_PER_BAUD+1 cycles.
  - The STOP period is never shortened.
- Counter: width $clog2(CLOCKS_PER_BAUD). It counts 0..CLOCKS_PER_BAUD-1, and the bit ends when count==CLOCKS_PER_BAUD-1, which wraps it to 0. The counter is held at 0 in IDLE.
- tx_busy = (state != IDLE); tx_byte_ready = (state == IDLE); both are registered-state decodes.
- Values 0x00 and 0xFF need no special case; 0xFF gives the start bit followed by 9 high bit periods.

Decomposition:
- Package uart_result_tx_pkg:
  - state enum {IDLE, START, DATA, STOP} (2 bits);
  - DATA_BITS=8;
  - FRAME_BITS=10.
- One natural sub-module, baud_tick_counter (parameter CLOCKS_PER_BAUD):
  - inputs clk, rst, clear;
  - output bit_end, a one-cycle pulse at count==CLOCKS_PER_BAUD-1.
- The FSM and shift register stay in the top module.

Test Plan:
- All scenarios use CLOCKS_PER_BAUD=4.
- Reset: hold rst for 3 cycles with tx_byte_valid=1 -> tx=1, ready=1, busy=0 throughout; no frame starts until the first edge with rst low.
- Single byte 0xA5: after the handshake, tx over 40 cycles = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each level held 4 cycles; ready=0 for those 40 cycles, then 1.
- Back-to-back 0x00 then 0xFF with valid held high: the second handshake occurs exactly 41 cycles after the first; the 0x00 frame shows tx low for 36 cycles; the 0xFF frame shows 4 low then 36 high.
- Valid while busy: pulse valid with 0x3C in the middle of the 0xA5 frame -> no acceptance, waveform unchanged; holding valid yields 0x3C sent immediately after.
- Reset mid-frame: assert rst during data bit 3 of 0x5A -> tx=1 the next cycle, ready=1 after release, and the next byte 0x81 is transmitted correctly.
- Random: 200 random bytes with random valid gaps; a reference UART sampler at mid-bit recovers every byte in order with the stop bit high.
